// File: rtl/multicycle_controller_if.sv
// Shared memory-port handshake between the multi-cycle controller and the memory.
// The controller owns the request side; memory answers with mem_ready.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core (shared memory port and ALU).
// Optional MC_CTRL_ILLEGAL_TRAP_EN: undecoded opcodes trap instead of retiring as NOP.
//
// state       | meaning
// FETCH    0  | read instruction at PC, PC <= PC+4
// DECODE   1  | ALUOut <= OldPC+imm, dispatch on opcode
// MEMADR   2  | ALUOut <= rs1+imm
// MEMREAD  3  | load data from ALUOut address
// MEMWB    4  | rd <= Data
// MEMWRITE 5  | store to ALUOut address
// EXECR    6  | rs1 op rs2
// EXECI    7  | rs1 op imm
// ALUWB    8  | rd <= ALUOut
// BRANCH   9  | compare, PC <= target if taken
// JAL     10  | PC <= target, ALUOut <= OldPC+4
// JALR    11  | PC <= rs1+imm
// LINK    12  | ALUOut <= OldPC+4
// LUI     13  | ALUOut <= 0+imm
// TRAP    14  | illegal opcode, hold until reset
module multicycle_controller (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        mem,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     funct3,
    input  logic                           funct7b5,
    input  logic                           branch_taken,
    output logic                           ir_write,
    output logic                           pc_write,
    output logic                           reg_write,
    output logic [1:0]                     alu_src_a,
    output logic [1:0]                     alu_src_b,
    output logic [2:0]                     alu_control,
    output logic                           alu_mod,
    output logic [1:0]                     result_src,
    output logic                           retire,
    output logic                           illegal,
    output logic [3:0]                     state
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd14,
        S_UNUSED   = 4'd15
    } state_t;

    state_t state_q, state_d;
    logic   legal;

    logic       mem_req_c, mem_write_c, adr_src_c;
    logic       ir_write_c, pc_write_c, reg_write_c, retire_c, alu_mod_c, illegal_c;
    logic [1:0] src_a_c, src_b_c, result_src_c;
    logic [2:0] alu_control_c;

    always_comb begin
        legal = 1'b1;
        case (opcode)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111: legal = 1'b1;
            default:    legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111:             state_d = S_LUI;
                    7'b0010111:             state_d = S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:                state_d = S_TRAP;
`else
                    default:                state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem.mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LINK, S_LUI: state_d = S_ALUWB;
            S_ALUWB, S_BRANCH: state_d = S_FETCH;
            S_JALR:     state_d = S_LINK;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req_c     = 1'b0;
        mem_write_c   = 1'b0;
        adr_src_c     = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        retire_c      = 1'b0;
        alu_mod_c     = 1'b0;
        illegal_c     = 1'b0;
        src_a_c       = 2'b00;
        src_b_c       = 2'b00;
        result_src_c  = 2'b00;
        alu_control_c = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
                ir_write_c   = mem.mem_ready;
                pc_write_c   = mem.mem_ready;
            end
            S_DECODE: begin
                src_a_c = 2'b01;
                src_b_c = 2'b01;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
                retire_c = ~legal;
`endif
            end
            S_MEMADR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                retire_c    = mem.mem_ready;
            end
            S_EXECR: begin
                src_a_c       = 2'b10;
                alu_control_c = funct3;
                alu_mod_c     = funct7b5 & ((funct3 == 3'b000) | (funct3 == 3'b101));
            end
            S_EXECI: begin
                src_a_c       = 2'b10;
                src_b_c       = 2'b01;
                alu_control_c = funct3;
                alu_mod_c     = funct7b5 & (funct3 == 3'b101);
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
            end
            S_BRANCH: begin
                src_a_c       = 2'b10;
                alu_control_c = funct3;
                pc_write_c    = branch_taken;
                retire_c      = 1'b1;
            end
            S_JAL: begin
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
                pc_write_c = 1'b1;
            end
            S_JALR: begin
                src_a_c      = 2'b10;
                src_b_c      = 2'b01;
                result_src_c = 2'b10;
                pc_write_c   = 1'b1;
            end
            S_LINK: begin
                src_a_c = 2'b01;
                src_b_c = 2'b10;
            end
            S_LUI: begin
                src_a_c = 2'b11;
                src_b_c = 2'b01;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:  illegal_c = 1'b1;
`endif
            default: ;
        endcase
    end

    // Reset masks everything immediately so a pending request drops without waiting for an edge.
    assign mem.mem_req   = mem_req_c   & ~reset;
    assign mem.mem_write = mem_write_c & ~reset;
    assign mem.adr_src   = adr_src_c   & ~reset;
    assign ir_write      = ir_write_c  & ~reset;
    assign pc_write      = pc_write_c  & ~reset;
    assign reg_write     = reg_write_c & ~reset;
    assign retire        = retire_c    & ~reset;
    assign alu_mod       = alu_mod_c   & ~reset;
    assign illegal       = illegal_c   & ~reset;
    assign alu_src_a     = reset ? 2'b00  : src_a_c;
    assign alu_src_b     = reset ? 2'b00  : src_b_c;
    assign result_src    = reset ? 2'b00  : result_src_c;
    assign alu_control   = reset ? 3'b000 : alu_control_c;
    assign state         = state_q;
endmodule
